tilt_gesture_decoder: RTL and testbench
=======================================

# tilt_gesture_decoder

Converts raw accelerometer samples from the SPI master into clean, single-cycle directional "whack" pulses for the game logic. It replaces the combinational tilt-to-button mapping and the four per-button debouncers with one block. The block applies clock-domain synchronisation, dominant-axis selection, enter/exit hysteresis and a hold-time qualifier. It sits between `spi_master` (4 MHz domain) and `whack_a_mole_advanced` (100 MHz domain).

## Interface
Parameters:
- `ENTER_THRESH`, default 6: magnitude (LSB) at which an axis counts as tilted; must be 1..15.
- `EXIT_THRESH`, default 3: magnitude below which an axis counts as level; must be < `ENTER_THRESH`.
- `HOLD_CYCLES`, default 500000: consecutive `clk` cycles (5 ms) a direction must persist before firing; must be ≥ 1.

Ports:
- `clk` in 1: 100 MHz system clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `acl_data` in 15: `{X[14:10], Y[9:5], Z[4:0]}`, each field 5-bit two's complement; asynchronous to `clk`; Z is ignored.
- `right_pulse` out 1: one-cycle pulse on a qualified +X tilt.
- `left_pulse` out 1: one-cycle pulse on a qualified −X tilt.
- `up_pulse` out 1: one-cycle pulse on a qualified +Y tilt.
- `bottom_pulse` out 1: one-cycle pulse on a qualified −Y tilt.
- `tilt_active` out 1: high while in FIRED state.
- `tilt_dir` out 2: direction of the current or last candidate; 0 = right, 1 = left, 2 = up, 3 = bottom.

## Operation
Input conditioning:
- `acl_data` passes through a 2-flop synchroniser (s1, s2) and then a third register s3.
- The stable sample register updates to s2 only when s2 == s3. A torn multi-bit capture is therefore never used.

Classification of the stable sample (combinational):
- |v| is computed in 5 bits. |−16| = 16.
- An axis is "tilted" if |v| ≥ `ENTER_THRESH`.
- The dominant direction is the tilted axis with the larger magnitude. On a tie, X wins. Sign selects right/left or up/bottom.
- "Level" means |X| < `EXIT_THRESH` and |Y| < `EXIT_THRESH`.

FSM states: NEUTRAL, CANDIDATE, FIRED.
- **NEUTRAL:** if a dominant direction exists, latch it into `tilt_dir`, load the counter with 1 and go to CANDIDATE.
- **CANDIDATE:**
  - If the dominant direction disappears, return to NEUTRAL.
  - If the dominant direction changes, relatch `tilt_dir`, reload the counter with 1 and stay in CANDIDATE.
  - Otherwise increment the counter.
  - When the counter equals `HOLD_CYCLES` with the same direction, go to FIRED and pulse the matching output for exactly that cycle.
- **FIRED:**
  - No further pulses are issued.
  - A return to NEUTRAL requires "level" for `HOLD_CYCLES` consecutive cycles, using the same counter. Any non-level cycle resets the count.
  - A direction change while in FIRED does not fire. The player must return to level first (no auto-repeat).
- At most one of the four pulse outputs is high in any cycle.
- Counter width is clog2(`HOLD_CYCLES`+1). It saturates and never wraps.

## Timing
- Reset values: all pulses 0, `tilt_active` 0, `tilt_dir` 0, state NEUTRAL, counter 0, synchroniser and stable registers 0.
- Pipeline latency:
  - A change on `acl_data` held steady reaches the stable register 4 `clk` edges later.
  - The classifier sees it in the same cycle the stable register updates.
- Fire latency: the first CANDIDATE cycle is count 1. The pulse is asserted on the cycle where count = `HOLD_CYCLES`, i.e. 4 + `HOLD_CYCLES` cycles after a steady input change from level.
- `tilt_active` rises on the cycle after the pulse and falls on the cycle after the level count completes.
- Reset mid-operation: a `reset` asserted in any state forces the reset values on the next edge. A pulse in flight is dropped. There is no pulse on reset release, even if the input is already tilted; the full hold qualification must elapse again.
- With `HOLD_CYCLES` = 1, a dominant direction fires on the first CANDIDATE cycle.

## Test plan
Bench parameters: `HOLD_CYCLES` = 8, `ENTER_THRESH` = 6, `EXIT_THRESH` = 3.

1. Hold X = +8, Y = 0 from level → `right_pulse` is high for exactly 1 cycle, 12 cycles after the change; `tilt_dir` = 0; `tilt_active` = 1 afterwards.
2. Hold X = 0, Y = −7 for 5 cycles, then return to 0 → no pulse; state returns to NEUTRAL.
3. Hold X = +7, Y = +7 (tie) → `right_pulse`. Then X = +6, Y = −9 from level → `bottom_pulse`.
4. Fire left with X = −10, then step to X = +10 without passing level → no second pulse. Set X = 0 for 8 cycles, then X = +10 → `right_pulse`.
5. In FIRED, hover at X = +4 (between thresholds) for 50 cycles → `tilt_active` stays 1 and no pulse. Alternate X = 2 and X = 4 every 5 cycles → never returns to NEUTRAL.
6. Assert `reset` at count 6 of a CANDIDATE, then release with X = +8 still applied → all outputs are 0 during reset; `right_pulse` fires 12 cycles after release.

Source files
------------

// File: rtl/tilt_gesture_decoder.sv
// tilt_gesture_decoder
// Turns raw accelerometer words from the SPI domain into single-cycle
// directional pulses. The path is: synchroniser, stable-sample filter,
// dominant-axis classifier, then a NEUTRAL/CANDIDATE/FIRED qualifier with
// enter/exit hysteresis and a hold time.
module tilt_gesture_decoder #(
    parameter int ENTER_THRESH = 6,
    parameter int EXIT_THRESH  = 3,
    parameter int HOLD_CYCLES  = 500000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [14:0] acl_data,
    output logic        right_pulse,
    output logic        left_pulse,
    output logic        up_pulse,
    output logic        bottom_pulse,
    output logic        tilt_active,
    output logic [1:0]  tilt_dir
);

    localparam int CW = $clog2(HOLD_CYCLES + 1);

    localparam logic [4:0]    ENTER_M = 5'(ENTER_THRESH);
    localparam logic [4:0]    EXIT_M  = 5'(EXIT_THRESH);
    localparam logic [CW-1:0] HOLD_C  = CW'(HOLD_CYCLES);
    localparam logic [CW-1:0] HOLD_M1 = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);

    typedef enum logic [1:0] {
        NEUTRAL   = 2'd0,
        CANDIDATE = 2'd1,
        FIRED     = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_RIGHT  = 2'd0,
        DIR_LEFT   = 2'd1,
        DIR_UP     = 2'd2,
        DIR_BOTTOM = 2'd3
    } dir_t;

    // Magnitude of a 5-bit two's complement value; -16 maps to 16 unsigned.
    function automatic logic [4:0] magnitude(input logic [4:0] v);
        return v[4] ? (~v + 5'd1) : v;
    endfunction

    logic [14:0] sync_s1, sync_s2, sync_s3;
    logic [9:0]  stable_xy;

    logic [4:0]  x_val, y_val, x_mag, y_mag;
    logic        x_tilt, y_tilt, dom_valid, level;
    dir_t        dom_dir;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    dir_t            dir_q, dir_d;
    logic            fire;

    // Synchronise the asynchronous word and accept it only once two
    // consecutive synchronised captures agree, so a torn word is never used.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            sync_s1   <= '0;
            sync_s2   <= '0;
            sync_s3   <= '0;
            stable_xy <= '0;
        end else begin
            sync_s1 <= acl_data;
            sync_s2 <= sync_s1;
            sync_s3 <= sync_s2;
            if (sync_s2 == sync_s3) begin
                stable_xy <= sync_s2[14:5];
            end
        end
    end

    // Classify the stable sample: dominant tilted axis (X wins ties) and level.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned and no latch is inferred.
        x_val     = stable_xy[9:5];
        y_val     = stable_xy[4:0];
        x_mag     = magnitude(x_val);
        y_mag     = magnitude(y_val);
        x_tilt    = (x_mag >= ENTER_M);
        y_tilt    = (y_mag >= ENTER_M);
        level     = (x_mag < EXIT_M) && (y_mag < EXIT_M);
        dom_valid = x_tilt || y_tilt;
        dom_dir   = DIR_RIGHT;
        if (x_tilt && (!y_tilt || (x_mag >= y_mag))) begin
            dom_dir = x_val[4] ? DIR_LEFT : DIR_RIGHT;
        end else if (y_tilt) begin
            dom_dir = y_val[4] ? DIR_BOTTOM : DIR_UP;
        end
    end

    // State, shared hold/level counter and latched direction registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= NEUTRAL;
            count_q <= '0;
            dir_q   <= DIR_RIGHT;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dir_q   <= dir_d;
        end
    end

    // Next-state logic: qualify a steady direction, then demand a steady
    // level period before re-arming (no auto-repeat).
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dir_d   = dir_q;
        fire    = 1'b0;
        case (state_q)
            NEUTRAL: begin
                count_d = '0;
                if (dom_valid) begin
                    dir_d   = dom_dir;
                    count_d = ONE;
                    state_d = CANDIDATE;
                end
            end
            CANDIDATE: begin
                if (!dom_valid) begin
                    state_d = NEUTRAL;
                    count_d = '0;
                end else if (dom_dir != dir_q) begin
                    dir_d   = dom_dir;
                    count_d = ONE;
                end else if (count_q >= HOLD_C) begin
                    fire    = 1'b1;
                    state_d = FIRED;
                    count_d = '0;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            FIRED: begin
                if (!level) begin
                    count_d = '0;
                end else if (count_q >= HOLD_M1) begin
                    state_d = NEUTRAL;
                    count_d = '0;
                end else begin
                    count_d = count_q + ONE;
                end
            end
            default: begin
                state_d = NEUTRAL;
                count_d = '0;
            end
        endcase
    end

    // Decode the qualifying cycle into one directional pulse; a pulse that
    // coincides with reset is dropped.
    always_comb begin
        right_pulse  = 1'b0;
        left_pulse   = 1'b0;
        up_pulse     = 1'b0;
        bottom_pulse = 1'b0;
        if (fire && !reset) begin
            case (dir_q)
                DIR_RIGHT:  right_pulse  = 1'b1;
                DIR_LEFT:   left_pulse   = 1'b1;
                DIR_UP:     up_pulse     = 1'b1;
                DIR_BOTTOM: bottom_pulse = 1'b1;
                default:    right_pulse  = 1'b0;
            endcase
        end
    end

    assign tilt_active = (state_q == FIRED);
    assign tilt_dir    = dir_q;

endmodule

// File: tb/tb_tilt_gesture_decoder.sv
// Directed bench for tilt_gesture_decoder with a pulse scoreboard: each
// qualifying stimulus pushes the expected direction and fire cycle, and a
// monitor pops and compares whenever the DUT emits a pulse.
module tb_tilt_gesture_decoder;

    localparam int HOLD    = 8;
    localparam int LATENCY = 4 + HOLD;

    localparam logic [1:0] D_RIGHT  = 2'd0;
    localparam logic [1:0] D_LEFT   = 2'd1;
    localparam logic [1:0] D_BOTTOM = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] acl_data;
    logic        right_pulse, left_pulse, up_pulse, bottom_pulse;
    logic        tilt_active;
    logic [1:0]  tilt_dir;
    logic [3:0]  pulses;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0] dir;
        int         cyc;
    } exp_t;

    exp_t sb_q[$];

    tilt_gesture_decoder #(
        .ENTER_THRESH (6),
        .EXIT_THRESH  (3),
        .HOLD_CYCLES  (HOLD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .acl_data     (acl_data),
        .right_pulse  (right_pulse),
        .left_pulse   (left_pulse),
        .up_pulse     (up_pulse),
        .bottom_pulse (bottom_pulse),
        .tilt_active  (tilt_active),
        .tilt_dir     (tilt_dir)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign pulses = {bottom_pulse, up_pulse, left_pulse, right_pulse};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic drive(input int x, input int y);
        acl_data = {5'(x), 5'(y), 5'd0};
    endtask

    // Expected pulse for a steady change applied in the current cycle.
    task automatic expect_pulse(input logic [1:0] dir);
        exp_t e;
        e.dir = dir;
        e.cyc = cyc + LATENCY;
        sb_q.push_back(e);
    endtask

    // Monitor: catch overdue, unexpected and mis-shaped pulses.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            check("pulse_overdue", cyc, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
        if (pulses != 4'b0000) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", pulses, 4'b0000);
            end else begin
                e = sb_q.pop_front();
                check("pulse_vector", pulses, 4'b0001 << e.dir);
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_dir", tilt_dir, e.dir);
            end
        end
    end

    initial begin
        reset = 1'b1;
        drive(0, 0);
        wait_cycles(3);
        check("reset_pulses", pulses, 4'b0000);
        check("reset_active", tilt_active, 1'b0);
        check("reset_dir", tilt_dir, 2'd0);
        reset = 1'b0;
        wait_cycles(2);

        // 1: right fire, single cycle, active afterwards, exact level exit
        drive(8, 0);
        expect_pulse(D_RIGHT);
        wait_cycles(LATENCY + 1);
        check("t1_active", tilt_active, 1'b1);
        check("t1_dir", tilt_dir, D_RIGHT);
        check("t1_single_pulse", right_pulse, 1'b0);
        drive(0, 0);
        wait_cycles(LATENCY - 1);
        check("t1_active_last_level", tilt_active, 1'b1);
        tick();
        check("t1_active_fall", tilt_active, 1'b0);

        // 2: short bottom candidate aborts
        drive(0, -7);
        wait_cycles(5);
        drive(0, 0);
        wait_cycles(20);
        check("t2_dir_latched", tilt_dir, D_BOTTOM);
        check("t2_inactive", tilt_active, 1'b0);

        // 3: tie goes to X, then Y-dominant bottom
        drive(7, 7);
        expect_pulse(D_RIGHT);
        wait_cycles(LATENCY + 2);
        check("t3_tie_dir", tilt_dir, D_RIGHT);
        check("t3_tie_active", tilt_active, 1'b1);
        drive(0, 0);
        wait_cycles(LATENCY + 2);
        check("t3_level", tilt_active, 1'b0);
        drive(6, -9);
        expect_pulse(D_BOTTOM);
        wait_cycles(LATENCY + 2);
        check("t3_bottom_dir", tilt_dir, D_BOTTOM);
        drive(0, 0);
        wait_cycles(LATENCY + 2);

        // 4: no re-fire on direction change in FIRED; re-arm after 8 level
        drive(-10, 0);
        expect_pulse(D_LEFT);
        wait_cycles(LATENCY + 2);
        check("t4_left_dir", tilt_dir, D_LEFT);
        drive(10, 0);
        wait_cycles(20);
        check("t4_fired_hold_dir", tilt_dir, D_LEFT);
        check("t4_fired_active", tilt_active, 1'b1);
        drive(0, 0);
        wait_cycles(HOLD);
        drive(10, 0);
        expect_pulse(D_RIGHT);
        wait_cycles(LATENCY + 2);
        check("t4_refire_active", tilt_active, 1'b1);

        // 5: hysteresis band keeps FIRED
        drive(4, 0);
        wait_cycles(50);
        check("t5_hover_active", tilt_active, 1'b1);
        for (int i = 0; i < 6; i++) begin
            drive(2, 0);
            wait_cycles(5);
            drive(4, 0);
            wait_cycles(5);
        end
        check("t5_alternate_active", tilt_active, 1'b1);
        drive(3, 0);
        wait_cycles(20);
        check("t5_exit_edge_active", tilt_active, 1'b1);
        drive(0, 0);
        wait_cycles(LATENCY - 1);
        check("t5_active_last_level", tilt_active, 1'b1);
        tick();
        check("t5_active_fall", tilt_active, 1'b0);

        // enter threshold boundary and the -16 magnitude
        drive(5, 0);
        wait_cycles(20);
        check("below_enter_inactive", tilt_active, 1'b0);
        drive(0, 0);
        wait_cycles(6);
        drive(-16, 0);
        expect_pulse(D_LEFT);
        wait_cycles(LATENCY + 2);
        check("neg16_dir", tilt_dir, D_LEFT);
        check("neg16_active", tilt_active, 1'b1);
        drive(0, 0);
        wait_cycles(LATENCY + 2);

        // 6: reset at count 6 of a candidate, release with tilt held
        drive(8, 0);
        wait_cycles(10);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6_reset_pulses", pulses, 4'b0000);
            check("t6_reset_active", tilt_active, 1'b0);
            check("t6_reset_dir", tilt_dir, 2'd0);
        end
        reset = 1'b0;
        expect_pulse(D_RIGHT);
        wait_cycles(LATENCY + 2);
        check("t6_active", tilt_active, 1'b1);
        drive(0, 0);
        wait_cycles(LATENCY + 2);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
